// File: rtl/mem_arbiter.sv
// Arbitrates one physical-memory port between the I-cache and D-cache miss paths.
// D-cache wins by default; a streak counter bounds how long a waiting I-fetch can starve.
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, TURN} state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                op_write;
  logic                d_pending;
  logic                d_wins;

  assign d_pending = d_read | d_write;
  assign d_wins    = d_pending && (!i_read || (streak < STREAK_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      streak       <= '0;
      op_write     <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_wins) begin
            state        <= SERVE_D;
            pmem_address <= d_address;
            pmem_wdata   <= d_wdata;
            // read+write together is resolved as a write
            op_write     <= d_write;
            if (!i_read)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + STREAK_W'(1);
          end else if (i_read) begin
            state        <= SERVE_I;
            pmem_address <= i_address;
            pmem_wdata   <= '0;
            op_write     <= 1'b0;
            streak       <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp)
            state <= TURN;
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and responses decode straight from registered state, so a stray
  // pmem_resp outside SERVE_x can never produce a cache response.
  always_comb begin
    pmem_read  = (state == SERVE_I) || ((state == SERVE_D) && !op_write);
    pmem_write = (state == SERVE_D) && op_write;
    i_resp     = (state == SERVE_I) && pmem_resp;
    d_resp     = (state == SERVE_D) && pmem_resp;
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
